// File: rtl/iram_pkg.sv
// rtl/iram_pkg.sv - shared state encoding and byte packing order for prog_iram
// Ports: none (package).
package iram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOAD   = 2'd2,
    ST_DONE_P = 2'd3
  } iram_state_t;

  // First byte of a word lands in the most-significant byte lane.
  localparam bit PACK_MSB_FIRST = 1'b1;

endpackage

// File: rtl/iram_byte_packer.sv
// rtl/iram_byte_packer.sv - assembles a stream of program bytes into instruction words
// Ports:
//   CLK        clock
//   restart    synchronous clear of byte index and partial word
//   in_valid   a byte transfers this cycle
//   in_data    the byte
//   in_last    the byte is the final byte of the image
//   word       assembled word including the current byte, unfilled lanes zero
//   word_valid word is complete this cycle (full or terminated by in_last)
//   last       the completing transfer carried in_last
module iram_byte_packer
  import iram_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              last
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = $clog2(BPW);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] acc;

  // acc holds earlier bytes in their lanes with zeros elsewhere, so a word
  // cut short by in_last is zero-padded without extra masking.
  always_comb begin
    word = acc;
    for (int b = 0; b < BPW; b++) begin
      if (idx == IDX_W'(b)) begin
        if (PACK_MSB_FIRST) word[DATA_W-8-8*b +: 8] = in_data;
        else                word[8*b +: 8]          = in_data;
      end
    end
  end

  assign word_valid = in_valid & ((idx == IDX_W'(BPW - 1)) | in_last);
  assign last       = in_valid & in_last;

  always_ff @(posedge CLK) begin
    if (restart) begin
      idx <= '0;
      acc <= '0;
    end else if (in_valid) begin
      if (word_valid) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + 1'b1;
        acc <= word;
      end
    end
  end

endmodule

// File: rtl/prog_iram.sv
// rtl/prog_iram.sv - loadable instruction RAM with byte-stream loader and CPU fetch port
// Ports:
//   CLK, RESET  clock, synchronous active-high reset (re-clears the memory)
//   ADDR        fetch byte address; Q is the word at ADDR, NOP while BUSY
//   MISALIGN    ADDR has nonzero low byte-offset bits
//   LD_START    begin a load from word 0 (honoured only when idle)
//   LD_VALID, LD_DATA, LD_LAST, LD_READY  byte stream handshake
//   BUSY        memory being cleared or loaded
//   LD_DONE     one-cycle pulse at load completion
//   LD_OVF      sticky, image exceeded DEPTH words
module prog_iram
  import iram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              MISALIGN,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              BUSY,
  output logic              LD_DONE,
  output logic              LD_OVF
);

  localparam int BPW   = DATA_W / 8;
  localparam int SH    = $clog2(BPW);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  iram_state_t       state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic              ovf_nxt;
  logic              start_load;
  logic              pk_restart;
  logic [DATA_W-1:0] pk_word;
  logic              pk_word_valid;
  logic              pk_last;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] widx;

  assign pk_restart = RESET | start_load;

  iram_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .CLK        (CLK),
    .restart    (pk_restart),
    .in_valid   (LD_VALID & LD_READY),
    .in_data    (LD_DATA),
    .in_last    (LD_LAST),
    .word       (pk_word),
    .word_valid (pk_word_valid),
    .last       (pk_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      LD_OVF <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      LD_OVF <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    ovf_nxt    = LD_OVF;
    start_load = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = pk_word;
    LD_READY   = 1'b0;
    BUSY       = 1'b0;
    LD_DONE    = 1'b0;
    case (state)
      ST_CLEAR: begin
        BUSY      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = '0;
        if (ptr == PTR_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (LD_START) begin
          start_load = 1'b1;
          state_nxt  = ST_LOAD;
          ptr_nxt    = '0;
          ovf_nxt    = 1'b0;
        end
      end
      ST_LOAD: begin
        BUSY     = 1'b1;
        LD_READY = 1'b1;
        if (pk_word_valid) begin
          mem_we = 1'b1;
          if (pk_last) begin
            state_nxt = ST_DONE_P;
          end else if (ptr == PTR_W'(DEPTH - 1)) begin
            // Image does not fit: keep the word that filled the memory, stop.
            ovf_nxt   = 1'b1;
            state_nxt = ST_DONE_P;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      ST_DONE_P: begin
        LD_DONE   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // A reset during LOAD must not commit the partial word.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) mem[ptr] <= mem_wdata;
  end

  assign widx     = ADDR >> SH;
  assign MISALIGN = |ADDR[SH-1:0];
  assign Q        = (!BUSY && (widx < ADDR_W'(DEPTH))) ? mem[widx[PTR_W-1:0]] : '0;

endmodule

// File: tb/tb_prog_iram.sv
// tb/tb_prog_iram.sv - self-checking bench for prog_iram
module tb_prog_iram;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  ADDR;
  logic [15:0] Q;
  logic        MISALIGN;
  logic        LD_START;
  logic        LD_VALID;
  logic [7:0]  LD_DATA;
  logic        LD_LAST;
  logic        LD_READY;
  logic        BUSY;
  logic        LD_DONE;
  logic        LD_OVF;

  prog_iram #(.DATA_W(16), .ADDR_W(8), .DEPTH(128)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ADDR     (ADDR),
    .Q        (Q),
    .MISALIGN (MISALIGN),
    .LD_START (LD_START),
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .LD_READY (LD_READY),
    .BUSY     (BUSY),
    .LD_DONE  (LD_DONE),
    .LD_OVF   (LD_OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] q;
    logic        mis;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  vec_t        vt[5];
  logic [15:0] model_mem[128];
  logic [7:0]  ld_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    check(name, n, 128);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      ADDR = vt[i].addr;
      #1;
      check($sformatf("%s_q@%02h", tag, vt[i].addr), Q, vt[i].q);
      check($sformatf("%s_mis@%02h", tag, vt[i].addr), MISALIGN, vt[i].mis);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e    = sb.pop_front();
      ADDR = e.addr;
      #1;
      check($sformatf("q@%02h", e.addr), Q, e.data);
    end
  endtask

  task automatic load(input bit toggle);
    int          n;
    int          nw;
    logic [7:0]  hi;
    logic [7:0]  lo;
    n = ld_q.size();
    LD_START = 1'b1;
    step();
    LD_START = 1'b0;
    check("ready_after_start", LD_READY, 1);
    for (int i = 0; i < n; i++) begin
      LD_VALID = 1'b1;
      LD_DATA  = ld_q[i];
      LD_LAST  = (i == n - 1);
      step();
      LD_VALID = 1'b0;
      LD_LAST  = 1'b0;
      if (toggle && i < n - 1) begin
        check("ready_in_gap", LD_READY, 1);
        step();
      end
    end
    check("done_pulse", LD_DONE, 1);
    check("busy_in_done", BUSY, 0);
    step();
    check("done_one_cycle", LD_DONE, 0);
    nw = (n + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      hi = ld_q[2*w];
      lo = 8'h00;
      if (2*w + 1 < n) lo = ld_q[2*w+1];
      model_mem[w] = {hi, lo};
      sb.push_back('{8'(2*w), {hi, lo}});
    end
    if (nw < 128) sb.push_back('{8'(2*nw), model_mem[nw]});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int nz;
    vt[0] = '{8'h00, 16'h0000, 1'b0};
    vt[1] = '{8'hFE, 16'h0000, 1'b0};
    vt[2] = '{8'h01, 16'h0000, 1'b1};
    vt[3] = '{8'h7F, 16'h0000, 1'b1};
    vt[4] = '{8'h80, 16'h0000, 1'b0};
    for (int w = 0; w < 128; w++) model_mem[w] = 16'h0000;

    RESET    = 1'b1;
    ADDR     = 8'h00;
    LD_START = 1'b0;
    LD_VALID = 1'b0;
    LD_DATA  = 8'h00;
    LD_LAST  = 1'b0;
    step();
    RESET = 1'b0;
    check("rst_busy", BUSY, 1);
    check("rst_ready", LD_READY, 0);
    check("rst_done", LD_DONE, 0);
    check("rst_ovf", LD_OVF, 0);
    wait_clear("clear_cycles");
    run_table("post_reset");

    ld_q = '{8'hF0, 8'h01, 8'hF2, 8'h91};
    load(1'b0);
    drain();

    ld_q = '{8'hAA, 8'hBB, 8'hCC};
    load(1'b0);
    drain();

    ld_q = '{8'hF0, 8'h01, 8'hF2, 8'h91};
    load(1'b1);
    drain();

    LD_START = 1'b1;
    step();
    LD_START = 1'b0;
    for (int i = 0; i < 258; i++) begin
      LD_VALID = 1'b1;
      LD_DATA  = 8'(i) ^ 8'h5A;
      LD_LAST  = 1'b0;
      if (i >= 256) check("ready_after_ovf", LD_READY, 0);
      step();
      if (i == 254) check("ovf_before_full", LD_OVF, 0);
      if (i == 255) begin
        check("ovf_set", LD_OVF, 1);
        check("ovf_done_pulse", LD_DONE, 1);
      end
    end
    LD_VALID = 1'b0;
    check("ovf_sticky", LD_OVF, 1);
    check("ovf_idle_busy", BUSY, 0);
    for (int w = 0; w < 128; w++) begin
      model_mem[w] = {8'(2*w) ^ 8'h5A, 8'(2*w+1) ^ 8'h5A};
      sb.push_back('{8'(2*w), model_mem[w]});
    end
    drain();

    LD_START = 1'b1;
    step();
    LD_START = 1'b0;
    check("ovf_cleared_on_start", LD_OVF, 0);
    ld_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int i = 0; i < 4; i++) begin
      LD_VALID = 1'b1;
      LD_DATA  = ld_q[i];
      step();
    end
    ADDR = 8'h00;
    #1;
    check("q_nop_while_busy", Q, 16'h0000);
    LD_DATA = ld_q[4];
    RESET   = 1'b1;
    step();
    RESET    = 1'b0;
    LD_VALID = 1'b0;
    check("abort_busy", BUSY, 1);
    check("abort_ready", LD_READY, 0);
    check("abort_done", LD_DONE, 0);
    wait_clear("reclear_cycles");
    for (int w = 0; w < 128; w++) model_mem[w] = 16'h0000;
    nz = 0;
    for (int a = 0; a < 256; a += 2) begin
      ADDR = 8'(a);
      #1;
      if (Q !== model_mem[a/2]) nz++;
    end
    check("all_zero_after_abort", nz, 0);
    run_table("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_iram.md
PROG_IRAM -- requirements
Module: prog_iram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter ADDR_W, default 8, fetch byte-address width.
REQ-003 SHALL have parameter DEPTH, default 128, number of instruction words; at most 2**(ADDR_W - log2(DATA_W/8)).
REQ-004 SHALL have port CLK, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port RESET, input, 1, reset; RESET is synchronous, active-high, clock CLK.
REQ-006 SHALL have port ADDR, input, ADDR_W, fetch byte address from the CPU PC.
REQ-007 SHALL have port Q, output, DATA_W, fetched instruction word.
REQ-008 SHALL have port MISALIGN, output, 1, ADDR not word-aligned.
REQ-009 SHALL have port LD_START, input, 1, begin program load.
REQ-010 SHALL have port LD_VALID, input, 1, LD_DATA holds a valid byte.
REQ-011 SHALL have port LD_DATA, input, 8, program byte.
REQ-012 SHALL have port LD_LAST, input, 1, current byte is the final byte of the image.
REQ-013 SHALL have port LD_READY, output, 1, block accepts a byte this cycle.
REQ-014 SHALL have port BUSY, output, 1, memory being cleared or loaded; CPU must hold in reset.
REQ-015 SHALL have port LD_DONE, output, 1, one-cycle pulse on load completion.
REQ-016 SHALL have port LD_OVF, output, 1, sticky: image exceeded DEPTH words.

Function
REQ-017 SHALL implement FSM states CLEAR, IDLE, LOAD, DONE_P.
REQ-018 In CLEAR, SHALL write zero to one word per cycle, pointer 0..DEPTH-1, then go to IDLE; CLEAR lasts DEPTH cycles.
REQ-019 In IDLE, LD_START=1 SHALL go to LOAD and reset the word pointer and byte index to 0; LD_START in other states SHALL be ignored.
REQ-020 LD_READY SHALL be 1 only in LOAD; a byte transfers when LD_VALID and LD_READY are both 1.
REQ-021 Bytes SHALL pack most-significant first: first byte of a word goes to bits DATA_W-1:DATA_W-8.
REQ-022 On the transfer completing a word, SHALL write the assembled word to mem[pointer] in that same edge and increment the pointer.
REQ-023 On a transfer with LD_LAST=1, SHALL zero-pad the remaining low bytes, write the word, and go to DONE_P.
REQ-024 DONE_P SHALL last one cycle with LD_DONE=1, then go to IDLE.
REQ-025 A word completing at pointer DEPTH-1 without LD_LAST SHALL set LD_OVF, write the word, and go to DONE_P; further bytes are not accepted.
REQ-026 BUSY SHALL be 1 in CLEAR and LOAD, and 0 otherwise.
REQ-027 Q SHALL be combinational: mem[ADDR >> log2(DATA_W/8)] when BUSY=0 and index < DEPTH; otherwise all-zero (NOP).
REQ-028 MISALIGN SHALL equal OR of ADDR low log2(DATA_W/8) bits; Q ignores those bits.
REQ-029 A reload (new LD_START) SHALL overwrite from word 0 without clearing; words beyond the new image keep old contents; LD_OVF is cleared on LD_START.

Reset
REQ-030 RESET SHALL force state CLEAR, pointer 0, byte index 0, LD_OVF=0, LD_DONE=0, LD_READY=0, BUSY=1 on the next edge.
REQ-031 RESET during LOAD SHALL abort the load; the partial word is discarded and the memory is re-cleared.

Structure
REQ-032 State encoding and the MSB-first packing order constant SHALL live in shared package iram_pkg.
REQ-033 Byte-to-word assembly SHALL be one sub-module, iram_byte_packer, with outputs word, word_valid, and last.

Verification
REQ-034 RESET 1 cycle -> BUSY=1 for exactly 128 cycles, then Q=0x0000 at ADDR 0x00 and 0xFE.
REQ-035 Load bytes F0,01,F2,91 with LD_LAST on the 4th byte -> LD_DONE pulse; ADDR 0x00 gives Q=0xF001 and ADDR 0x02 gives Q=0xF291.
REQ-036 Load 3 bytes AA,BB,CC with LD_LAST on CC -> ADDR 0x02 gives Q=0xCC00.
REQ-037 LD_VALID toggling every other cycle -> identical memory contents; LD_READY stays 1 throughout LOAD.
REQ-038 Stream 258 bytes with no LD_LAST -> LD_OVF=1 after byte 256, and LD_READY=0 afterwards.
REQ-039 RESET asserted at byte 5 of a load, then ADDR 0x01 -> all words zero after CLEAR, and MISALIGN=1.
